// File: rtl/trap_controller_if.sv
// trap_controller_if: exception/CSR/redirect bundle between the pipeline and trap_controller
// master: pipeline side (raises exceptions and MRET, accesses CSRs, consumes redirects)
// slave : trap_controller
// TRAP_CTRL_IRQ_EN adds the ext_irq line.
interface trap_controller_if;
  logic        if_exc_valid;
  logic [3:0]  if_exc_cause;
  logic        dec_exc_valid;
  logic [3:0]  dec_exc_cause;
  logic [31:0] dec_inst;
  logic        ls_exc_valid;
  logic [3:0]  ls_exc_cause;
  logic [31:0] ls_exc_addr;
  logic [31:0] current_pc;
  logic        mret_req;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        stall;
  logic        flush;
  logic        trap_enable;
  logic [31:0] trap_handler_addr;
  logic        xret_enable;
  logic [31:0] epc_value;
`ifdef TRAP_CTRL_IRQ_EN
  logic        ext_irq;
`endif
  modport master(
`ifdef TRAP_CTRL_IRQ_EN
    output ext_irq,
`endif
    output if_exc_valid, if_exc_cause, dec_exc_valid, dec_exc_cause, dec_inst,
    output ls_exc_valid, ls_exc_cause, ls_exc_addr, current_pc, mret_req,
    output csr_wr_en, csr_addr, csr_wr_data,
    input  csr_rd_data, stall, flush, trap_enable, trap_handler_addr, xret_enable, epc_value
  );
  modport slave(
`ifdef TRAP_CTRL_IRQ_EN
    input  ext_irq,
`endif
    input  if_exc_valid, if_exc_cause, dec_exc_valid, dec_exc_cause, dec_inst,
    input  ls_exc_valid, ls_exc_cause, ls_exc_addr, current_pc, mret_req,
    input  csr_wr_en, csr_addr, csr_wr_data,
    output csr_rd_data, stall, flush, trap_enable, trap_handler_addr, xret_enable, epc_value
  );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer owning mtvec/mepc/mcause/mtval/mstatus
// Ports: clk, rst (sync, active-high); bus (trap_controller_if.slave) carries the
//   exception publishers, mret_req, CSR read/write port and the redirect/flush/stall outputs.
// Optional: TRAP_CTRL_IRQ_EN adds ext_irq, mie (0x304, MEIE), mip (0x344, MEIP) and vectored mtvec.
module trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input logic clk,
  input logic rst,
  trap_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
  state_t      r_state;
  logic [31:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_tval, r_pc;
  logic [3:0]  r_cause;
  logic        r_irq, r_mie, r_mpie;
  logic        r_stall, r_flush, r_trap_enable, r_xret_enable;
  logic        w_exc, w_take_irq, w_vec;
  logic [3:0]  w_cause;
  logic [31:0] w_tval, w_base, w_rd, w_mstatus;
`ifdef TRAP_CTRL_IRQ_EN
  logic        r_meie;
  assign w_take_irq = bus.ext_irq & r_mie & r_meie & ~w_exc & ~bus.mret_req;
  assign w_vec      = r_mtvec[0] & r_irq;
`else
  assign w_take_irq = 1'b0;
  assign w_vec      = 1'b0;
`endif
  assign w_exc   = bus.if_exc_valid | bus.dec_exc_valid | bus.ls_exc_valid;
  assign w_cause = bus.if_exc_valid ? bus.if_exc_cause :
                   bus.dec_exc_valid ? bus.dec_exc_cause : bus.ls_exc_cause;
  assign w_tval  = bus.if_exc_valid ? bus.current_pc :
                   bus.dec_exc_valid ? ((bus.dec_exc_cause == 4'd2) ? bus.dec_inst : 32'd0) :
                   bus.ls_exc_addr;
  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
  assign w_base    = {r_mtvec[31:2], 2'b00};
  always_comb begin
    w_rd = (bus.csr_addr == 12'h300) ? w_mstatus :
           (bus.csr_addr == 12'h305) ? r_mtvec :
           (bus.csr_addr == 12'h341) ? r_mepc :
           (bus.csr_addr == 12'h342) ? r_mcause :
           (bus.csr_addr == 12'h343) ? r_mtval :
`ifdef TRAP_CTRL_IRQ_EN
           (bus.csr_addr == 12'h304) ? {20'd0, r_meie, 11'd0} :
           (bus.csr_addr == 12'h344) ? {20'd0, bus.ext_irq, 11'd0} :
`endif
           32'd0;
  end
  assign bus.csr_rd_data       = w_rd;
  assign bus.stall             = r_stall;
  assign bus.flush             = r_flush;
  assign bus.trap_enable       = r_trap_enable;
  assign bus.xret_enable       = r_xret_enable;
  assign bus.epc_value         = r_mepc;
  // r_mtvec is only committed at the end of the TRAP cycle, so a same-cycle write cannot move the target
  assign bus.trap_handler_addr = r_trap_enable ? (w_vec ? w_base + 32'd44 : w_base) : 32'd0;
  // CSR writes come first so the trap/return commit below overrides the fields it owns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mtvec       <= {MTVEC_RESET[31:2], 2'b00};
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_tval        <= '0;
      r_pc          <= '0;
      r_cause       <= '0;
      r_irq         <= 1'b0;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_trap_enable <= 1'b0;
      r_xret_enable <= 1'b0;
`ifdef TRAP_CTRL_IRQ_EN
      r_meie        <= 1'b0;
`endif
    end else begin
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_trap_enable <= 1'b0;
      r_xret_enable <= 1'b0;
      if (bus.csr_wr_en) begin
        if (bus.csr_addr == 12'h300) begin
          r_mie  <= bus.csr_wr_data[3];
          r_mpie <= bus.csr_wr_data[7];
        end
`ifdef TRAP_CTRL_IRQ_EN
        if (bus.csr_addr == 12'h305) r_mtvec <= {bus.csr_wr_data[31:2], 1'b0, bus.csr_wr_data[0]};
        if (bus.csr_addr == 12'h304) r_meie <= bus.csr_wr_data[11];
`else
        if (bus.csr_addr == 12'h305) r_mtvec <= {bus.csr_wr_data[31:2], 2'b00};
`endif
        if (bus.csr_addr == 12'h341) r_mepc <= {bus.csr_wr_data[31:2], 2'b00};
        if (bus.csr_addr == 12'h342) r_mcause <= bus.csr_wr_data;
        if (bus.csr_addr == 12'h343) r_mtval <= bus.csr_wr_data;
      end
      case (r_state)
        IDLE: begin
          if (w_exc || w_take_irq) begin
            r_state       <= TRAP;
            r_cause       <= w_cause;
            r_tval        <= w_exc ? w_tval : 32'd0;
            r_irq         <= ~w_exc;
            r_pc          <= bus.current_pc;
            r_stall       <= 1'b1;
            r_flush       <= 1'b1;
            r_trap_enable <= 1'b1;
          end else if (bus.mret_req) begin
            r_state       <= RET;
            r_stall       <= 1'b1;
            r_flush       <= 1'b1;
            r_xret_enable <= 1'b1;
          end
        end
        TRAP: begin
          r_state  <= IDLE;
          r_mepc   <= {r_pc[31:2], 2'b00};
          r_mcause <= r_irq ? 32'h8000_000B : {28'd0, r_cause};
          r_mtval  <= r_tval;
          r_mpie   <= r_mie;
          r_mie    <= 1'b0;
        end
        RET: begin
          r_state <= IDLE;
          r_mie   <= r_mpie;
          r_mpie  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed stimulus with a per-cycle behavioural model plus literal checks
module tb_trap_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  trap_controller_if bus();
  trap_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef TRAP_CTRL_IRQ_EN
  localparam logic [31:0] MTV_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MTV_403  = 32'h0000_0401;
`else
  localparam logic [31:0] MTV_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] MTV_403  = 32'h0000_0400;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  // model: architectural CSR values plus the redirect expected in the current cycle
  bit          m_ok = 1'b0;
  int          m_busy;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, p_pc, p_cause, p_tval;
  logic        m_mie, m_mpie, m_meie, p_irq, m_irq;
`ifdef TRAP_CTRL_IRQ_EN
  assign m_irq = bus.ext_irq & m_mie & m_meie;
`else
  assign m_irq = 1'b0;
`endif
  always @(posedge clk) begin
    m_ok <= 1'b1;
    if (rst) begin
      m_busy <= 0; m_mtvec <= 32'h100; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_mie <= 0; m_mpie <= 0; m_meie <= 0; p_irq <= 0; p_pc <= 0; p_cause <= 0; p_tval <= 0;
    end else begin
      m_busy <= 0;
      if (bus.csr_wr_en)
        case (bus.csr_addr)
          12'h300: begin m_mie <= bus.csr_wr_data[3]; m_mpie <= bus.csr_wr_data[7]; end
          12'h305: m_mtvec <= bus.csr_wr_data & MTV_MASK;
          12'h341: m_mepc <= bus.csr_wr_data & 32'hFFFF_FFFC;
          12'h342: m_mcause <= bus.csr_wr_data;
          12'h343: m_mtval <= bus.csr_wr_data;
`ifdef TRAP_CTRL_IRQ_EN
          12'h304: m_meie <= bus.csr_wr_data[11];
`endif
          default: ;
        endcase
      if (m_busy == 1) begin
        m_mepc <= p_pc & 32'hFFFF_FFFC; m_mcause <= p_cause; m_mtval <= p_tval;
        m_mpie <= m_mie; m_mie <= 0;
      end else if (m_busy == 2) begin
        m_mie <= m_mpie; m_mpie <= 1;
      end else if (bus.if_exc_valid) begin
        m_busy <= 1; p_irq <= 0; p_cause <= {28'd0, bus.if_exc_cause};
        p_tval <= bus.current_pc; p_pc <= bus.current_pc;
      end else if (bus.dec_exc_valid) begin
        m_busy <= 1; p_irq <= 0; p_cause <= {28'd0, bus.dec_exc_cause};
        p_tval <= (bus.dec_exc_cause == 4'd2) ? bus.dec_inst : 0; p_pc <= bus.current_pc;
      end else if (bus.ls_exc_valid) begin
        m_busy <= 1; p_irq <= 0; p_cause <= {28'd0, bus.ls_exc_cause};
        p_tval <= bus.ls_exc_addr; p_pc <= bus.current_pc;
      end else if (bus.mret_req) m_busy <= 2;
      else if (m_irq) begin
        m_busy <= 1; p_irq <= 1; p_cause <= 32'h8000_000B; p_tval <= 0; p_pc <= bus.current_pc;
      end
    end
  end
  function automatic logic [31:0] mrd(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
`ifdef TRAP_CTRL_IRQ_EN
      12'h304: return 32'(m_meie) << 11;
      12'h344: return 32'(bus.ext_irq) << 11;
`endif
      default: return 0;
    endcase
  endfunction
  always @(negedge clk) if (m_ok) begin
    chk("stall", 32'(bus.stall), 32'(m_busy != 0));
    chk("flush", 32'(bus.flush), 32'(m_busy != 0));
    chk("trap_enable", 32'(bus.trap_enable), 32'(m_busy == 1));
    chk("xret_enable", 32'(bus.xret_enable), 32'(m_busy == 2));
    chk("trap_handler_addr", bus.trap_handler_addr, (m_busy == 1) ?
        (m_mtvec & 32'hFFFF_FFFC) + ((p_irq && m_mtvec[0]) ? 32'd44 : 32'd0) : 32'd0);
    chk("epc_value", bus.epc_value, m_mepc);
    chk("csr_rd_data", bus.csr_rd_data, mrd(bus.csr_addr));
  end
  task automatic nx();
    @(posedge clk); #1;
  endtask
  task automatic clr();
    bus.if_exc_valid = 0; bus.if_exc_cause = 0; bus.dec_exc_valid = 0; bus.dec_exc_cause = 0;
    bus.dec_inst = 0; bus.ls_exc_valid = 0; bus.ls_exc_cause = 0; bus.ls_exc_addr = 0;
    bus.current_pc = 0; bus.mret_req = 0; bus.csr_wr_en = 0; bus.csr_addr = 0; bus.csr_wr_data = 0;
`ifdef TRAP_CTRL_IRQ_EN
    bus.ext_irq = 0;
`endif
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr_en = 1; bus.csr_addr = a; bus.csr_wr_data = d;
    nx();
    bus.csr_wr_en = 0;
  endtask
  task automatic rdc(input string n, input logic [11:0] a, input logic [31:0] e);
    bus.csr_addr = a; #1;
    chk(n, bus.csr_rd_data, e);
  endtask
  initial begin
    clr();
    nx(); nx();
    rst = 0;
    rdc("reset mtvec", 12'h305, 32'h0000_0100);
    rdc("reset mstatus", 12'h300, 32'h0000_1800);
    rdc("reset mepc", 12'h341, 32'h0);
    rdc("unowned csr", 12'h304, 32'h0);
    wr(12'h300, 32'h8);
    bus.dec_exc_valid = 1; bus.dec_exc_cause = 4'd11; bus.dec_inst = 32'hDEAD_BEEF; bus.current_pc = 32'h2004;
    nx(); clr();
    @(negedge clk);
    chk("ecall trap_enable", 32'(bus.trap_enable), 32'd1);
    chk("ecall handler", bus.trap_handler_addr, 32'h0000_0100);
    nx();
    rdc("ecall mepc", 12'h341, 32'h0000_2004);
    rdc("ecall mcause", 12'h342, 32'd11);
    rdc("ecall mtval", 12'h343, 32'd0);
    rdc("ecall mstatus", 12'h300, 32'h0000_1880);
    bus.if_exc_valid = 1; bus.if_exc_cause = 4'd1; bus.ls_exc_valid = 1; bus.ls_exc_cause = 4'd5;
    bus.ls_exc_addr = 32'h5555; bus.current_pc = 32'h3000;
    nx(); clr(); nx();
    rdc("prio mcause", 12'h342, 32'd1);
    rdc("prio mtval", 12'h343, 32'h0000_3000);
    wr(12'h341, 32'h0000_200B);
    wr(12'h300, 32'h80);
    rdc("mepc mask", 12'h341, 32'h0000_2008);
    bus.mret_req = 1;
    nx(); clr();
    @(negedge clk);
    chk("mret xret_enable", 32'(bus.xret_enable), 32'd1);
    chk("mret epc_value", bus.epc_value, 32'h0000_2008);
    nx();
    rdc("mret mstatus", 12'h300, 32'h0000_1888);
    bus.dec_exc_valid = 1; bus.dec_exc_cause = 4'd2; bus.dec_inst = 32'h0000_FFFF;
    bus.current_pc = 32'h4000; bus.mret_req = 1;
    nx(); clr();
    @(negedge clk);
    chk("exc+mret xret", 32'(bus.xret_enable), 32'd0);
    chk("exc+mret trap", 32'(bus.trap_enable), 32'd1);
    nx();
    rdc("illegal mcause", 12'h342, 32'd2);
    rdc("illegal mtval", 12'h343, 32'h0000_FFFF);
    bus.ls_exc_valid = 1; bus.ls_exc_cause = 4'd7; bus.ls_exc_addr = 32'h8000_0010; bus.current_pc = 32'h5000;
    nx(); clr();
    bus.csr_wr_en = 1; bus.csr_addr = 12'h305; bus.csr_wr_data = 32'h0000_0403;
    @(negedge clk);
    chk("old mtvec target", bus.trap_handler_addr, 32'h0000_0100);
    nx(); clr();
    rdc("new mtvec", 12'h305, MTV_403);
    rdc("store mtval", 12'h343, 32'h8000_0010);
    bus.if_exc_valid = 1; bus.if_exc_cause = 4'd0; bus.current_pc = 32'h6002;
    nx(); clr();
    @(negedge clk);
    chk("new mtvec target", bus.trap_handler_addr, 32'h0000_0400);
    nx();
    rdc("misalign mepc", 12'h341, 32'h0000_6000);
    rdc("misalign mtval", 12'h343, 32'h0000_6002);
    bus.dec_exc_valid = 1; bus.dec_exc_cause = 4'd3; bus.current_pc = 32'h6100;
    nx(); clr();
    bus.ls_exc_valid = 1; bus.ls_exc_cause = 4'd4; bus.ls_exc_addr = 32'h99; bus.current_pc = 32'h6200;
    bus.csr_wr_en = 1; bus.csr_addr = 12'h342; bus.csr_wr_data = 32'h1234;
    nx(); clr();
    @(negedge clk);
    chk("ignored in TRAP", 32'(bus.trap_enable), 32'd0);
    rdc("ebreak mcause", 12'h342, 32'd3);
    rdc("ebreak mepc", 12'h341, 32'h0000_6100);
    rdc("ebreak mtval", 12'h343, 32'd0);
    wr(12'h342, 32'hFFFF_FFFF);
    rdc("mcause full", 12'h342, 32'hFFFF_FFFF);
    wr(12'h343, 32'h1234_5677);
    rdc("mtval full", 12'h343, 32'h1234_5677);
    bus.dec_exc_valid = 1; bus.dec_exc_cause = 4'd11; bus.current_pc = 32'h8000;
    nx(); clr(); rst = 1;
    @(negedge clk);
    chk("pre-reset trap", 32'(bus.trap_enable), 32'd1);
    nx();
    @(negedge clk);
    chk("reset kills pulse", 32'(bus.trap_enable), 32'd0);
    rst = 0;
    rdc("reset mepc again", 12'h341, 32'h0);
    rdc("reset mtvec again", 12'h305, 32'h0000_0100);
    rdc("reset mstatus again", 12'h300, 32'h0000_1800);
`ifdef TRAP_CTRL_IRQ_EN
    nx();
    wr(12'h304, 32'h800);
    wr(12'h305, 32'h0000_0401);
    wr(12'h300, 32'h8);
    bus.ext_irq = 1; bus.current_pc = 32'h7000;
    nx(); clr();
    @(negedge clk);
    chk("irq handler", bus.trap_handler_addr, 32'h0000_042C);
    nx();
    rdc("irq mcause", 12'h342, 32'h8000_000B);
    rdc("irq mepc", 12'h341, 32'h0000_7000);
    wr(12'h300, 32'h8);
    bus.ext_irq = 1; bus.dec_exc_valid = 1; bus.dec_exc_cause = 4'd2; bus.dec_inst = 32'h13;
    bus.current_pc = 32'h7100;
    nx(); clr();
    @(negedge clk);
    chk("exc beats irq addr", bus.trap_handler_addr, 32'h0000_0400);
    nx();
    rdc("exc beats irq mcause", 12'h342, 32'd2);
`else
    rdc("no mip", 12'h344, 32'h0);
`endif
    nx(); nx();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
